uart_rx_param: RTL and testbench

- Parametrised UART receiver; next generation of the single-width serial input block.
- Adds configurable data width, optional even/odd parity, 1 or 2 stop bits, oversampled mid-bit sampling, false-start rejection, framing error, and a one-cycle valid strobe.
- Sits between the serial pin and byte-level consumers (FIFO, command decoder); the baud generator supplies the oversample tick.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_parity_calc.sv | 15 +
 rtl/uart_rx_param.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and configuration checks.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  function automatic bit cfg_ok(input int data_bits, input int oversample,
                                input int parity_mode, input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 4) && ((oversample % 2) == 0) &&
           (parity_mode >= PARITY_NONE) && (parity_mode <= PARITY_ODD) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit a transmitter would send for a payload; shared by the UART receiver and transmitter.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic             parity_o
);

  // Even mode makes the total count of ones even; odd mode inverts that bit.
  assign parity_o = (^data_i) ^ (mode_i == 2'(PARITY_ODD));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled mid-bit sampling, parity/framing checks and break hold-off.
//
// state      | meaning
// IDLE       | line idle, waiting for rx_s low on a tick
// START      | confirming the start bit at its middle
// DATA       | sampling payload bits, LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling stop bits
// BREAK_WAIT | framing error seen, waiting for the line to return high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 baud_tick_i,
  input  logic                 in_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 busy_o
);

  localparam int              TW         = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   TICK_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
  localparam bit              HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  if (!cfg_ok(DATA_BITS, OVERSAMPLE, PARITY_MODE, STOP_BITS)) begin : g_bad_cfg
    $error("uart_rx_param: illegal DATA_BITS/OVERSAMPLE/PARITY_MODE/STOP_BITS");
  end

  rx_state_e              state_q, state_d;
  logic [1:0]             sync_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q;
  logic                   perr_q, perr_d;
  logic                   fout_q, fout_d;

  logic                   rx_s;
  logic                   par_exp;
  logic                   perr_calc;
  logic                   stop_err;

  assign rx_s = sync_q[1];

  uart_parity_calc #(.WIDTH(DATA_BITS)) u_parity (
    .data_i   (shift_q),
    .mode_i   (2'(PARITY_MODE)),
    .parity_o (par_exp)
  );

  assign perr_calc = HAS_PARITY && (par_bit_q != par_exp);
  assign stop_err  = ferr_q | ~rx_s;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      fout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], in_i};
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      data_q    <= data_d;
      valid_q   <= done_q;
      perr_q    <= perr_d;
      fout_q    <= fout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (baud_tick_i && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (baud_tick_i) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            bit_d  = '0;
            ferr_d = 1'b0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = HAS_PARITY ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            par_bit_d = rx_s;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            ferr_d = stop_err;
            if (bit_q == STOP_LAST) begin
              // Leave STOP at the last mid-sample so a start edge half a bit later is caught.
              bit_d   = '0;
              done_d  = 1'b1;
              state_d = stop_err ? BREAK_WAIT : IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      BREAK_WAIT: begin
        if (baud_tick_i && rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    perr_d = perr_q;
    fout_d = fout_q;
    if (done_q) begin
      data_d = shift_q;
      perr_d = perr_calc;
      fout_d = ferr_q;
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign parity_error_o = perr_q;
  assign frame_error_o  = fout_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomized frames on two receiver configurations, checked against a frame-level model.
module tb_uart_rx_param;

  localparam int OS = 16;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic       baud;
  logic       line_a, line_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       dv_a, pe_a, fe_a, busy_a;
  logic       dv_b, pe_b, fe_b, busy_b;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  rec_t qa[$];
  rec_t qb[$];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .baud_tick_i(baud), .in_i(line_a),
    .data_o(data_a), .data_valid_o(dv_a), .parity_error_o(pe_a),
    .frame_error_o(fe_a), .busy_o(busy_a)
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_MODE(2), .STOP_BITS(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .baud_tick_i(baud), .in_i(line_b),
    .data_o(data_b), .data_valid_o(dv_b), .parity_error_o(pe_b),
    .frame_error_o(fe_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv_a) qa.push_back('{d: 9'(data_a), pe: pe_a, fe: fe_a, cyc: cyc});
    if (dv_b) qb.push_back('{d: 9'(data_b), pe: pe_b, fe: fe_b, cyc: cyc});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity bit a correct transmitter sends: pm 1 = even total, pm 2 = odd total.
  function automatic logic good_pb(input logic [8:0] d, input int pm);
    int ones = $countones(d);
    return (pm == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic model_pe(input logic [8:0] d, input int pm, input logic pb);
    int ones;
    if (pm == 0) return 1'b0;
    ones = $countones(d) + int'(pb);
    return (pm == 2) ? ((ones % 2) != 1) : ((ones % 2) != 0);
  endfunction

  function automatic int latency(input int nd, input int np, input int ns);
    return (1 + nd + np + ns) * OS - OS / 2 + 1 + 2;
  endfunction

  task automatic drive(input bit b, input logic v, input int n);
    if (b) line_b = v;
    else   line_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit b, input int nd, input logic [8:0] d, input bit hp,
                            input logic pb, input int ns, input logic [1:0] st, output int sc);
    sc = cyc;
    drive(b, 1'b0, OS);
    for (int i = 0; i < nd; i++) drive(b, d[i], OS);
    if (hp) drive(b, pb, OS);
    for (int i = 0; i < ns; i++) drive(b, st[i], OS);
  endtask

  task automatic chk_rec(input string tag, input rec_t r, input logic [8:0] d,
                         input logic pe, input logic fe);
    chk({tag, "_data"}, 32'(r.d), 32'(d));
    chk({tag, "_perr"}, 32'(r.pe), 32'(pe));
    chk({tag, "_ferr"}, 32'(r.fe), 32'(fe));
  endtask

  initial begin
    int         n0, sc, sc2, gap, cnt;
    logic [8:0] d, d2;
    logic       pb, bp, bs;
    rec_t       exp_q[$];

    rst_n  = 1'b0;
    baud   = 1'b1;
    line_a = 1'b1;
    line_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_a_data", 32'(data_a), 32'd0);
    chk("rst_a_dv",   32'(dv_a),   32'd0);
    chk("rst_a_perr", 32'(pe_a),   32'd0);
    chk("rst_a_ferr", 32'(fe_a),   32'd0);
    chk("rst_a_busy", 32'(busy_a), 32'd0);
    chk("rst_b_data", 32'(data_b), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Clean 0xA5, even parity.
    n0 = qa.size();
    d  = 9'h0A5;
    send_frame(0, 8, d, 1, good_pb(d, 1), 1, 2'b01, sc);
    drive(0, 1'b1, OS);
    chk("a5_count", 32'(qa.size() - n0), 32'd1);
    if (qa.size() > n0) begin
      chk_rec("a5", qa[$], d, 1'b0, 1'b0);
      chk("a5_latency", 32'(qa[$].cyc - sc - 1), 32'(latency(8, 1, 1)));
    end
    chk("a5_busy", 32'(busy_a), 32'd0);

    // Same payload with a wrong parity bit, then a clean 0x3C clears the flag.
    n0 = qa.size();
    send_frame(0, 8, d, 1, ~good_pb(d, 1), 1, 2'b01, sc);
    drive(0, 1'b1, OS);
    d2 = 9'h03C;
    send_frame(0, 8, d2, 1, good_pb(d2, 1), 1, 2'b01, sc);
    drive(0, 1'b1, OS);
    chk("perr_count", 32'(qa.size() - n0), 32'd2);
    if (qa.size() >= n0 + 2) begin
      chk_rec("a5_bad_par", qa[n0], d, 1'b1, 1'b0);
      chk_rec("3c_clean", qa[n0 + 1], d2, 1'b0, 1'b0);
    end

    // Break: 0x00 with a low stop bit, then the line held low for 40 bit times.
    n0 = qa.size();
    d  = 9'h000;
    send_frame(0, 8, d, 1, good_pb(d, 1), 1, 2'b00, sc);
    drive(0, 1'b0, 40 * OS);
    chk("break_count", 32'(qa.size() - n0), 32'd1);
    if (qa.size() > n0) chk_rec("break", qa[$], d, 1'b0, 1'b1);
    chk("break_busy", 32'(busy_a), 32'd1);
    drive(0, 1'b1, 2 * OS);
    chk("break_release", 32'(busy_a), 32'd0);
    n0 = qa.size();
    d  = 9'h055;
    send_frame(0, 8, d, 1, good_pb(d, 1), 1, 2'b01, sc);
    drive(0, 1'b1, OS);
    chk("after_break_count", 32'(qa.size() - n0), 32'd1);
    if (qa.size() > n0) chk_rec("after_break", qa[$], d, 1'b0, 1'b0);

    // False start: a 4-tick glitch must be rejected.
    n0 = qa.size();
    drive(0, 1'b0, 4);
    line_a = 1'b1;
    cnt = 0;
    while (busy_a !== 1'b0 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("glitch_busy_clear", 32'(busy_a), 32'd0);
    drive(0, 1'b1, 2 * OS);
    chk("glitch_no_valid", 32'(qa.size() - n0), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF.
    n0 = qa.size();
    drive(0, 1'b0, OS);
    drive(0, 1'b1, 4 * OS + OS / 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_data", 32'(data_a), 32'd0);
    chk("midrst_dv",   32'(dv_a),   32'd0);
    chk("midrst_perr", 32'(pe_a),   32'd0);
    chk("midrst_ferr", 32'(fe_a),   32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    drive(0, 1'b1, 12 * OS);
    chk("midrst_no_valid", 32'(qa.size() - n0), 32'd0);
    n0 = qa.size();
    d  = 9'h081;
    send_frame(0, 8, d, 1, good_pb(d, 1), 1, 2'b01, sc);
    drive(0, 1'b1, OS);
    chk("after_rst_count", 32'(qa.size() - n0), 32'd1);
    if (qa.size() > n0) chk_rec("after_rst", qa[$], d, 1'b0, 1'b0);

    // Random burst with occasional parity and stop errors and 0..2 bit gaps.
    n0 = qa.size();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d  = 9'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      pb = good_pb(d, 1) ^ bp;
      exp_q.push_back('{d: d, pe: model_pe(d, 1, pb), fe: bs, cyc: 0});
      send_frame(0, 8, d, 1, pb, 1, bs ? 2'b00 : 2'b01, sc);
      gap = bs ? (1 + $urandom_range(0, 1)) : $urandom_range(0, 2);
      if (gap > 0) drive(0, 1'b1, gap * OS);
    end
    drive(0, 1'b1, 2 * OS);
    chk("rand_count", 32'(qa.size() - n0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (n0 + i < qa.size()) chk_rec($sformatf("rand%0d", i), qa[n0 + i], exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
    end

    // 7 data bits, odd parity, two stops: 0x41 with second stop low.
    n0 = qb.size();
    d  = 9'h041;
    pb = 1'b1;
    send_frame(1, 7, d, 1, pb, 2, 2'b01, sc);
    drive(1, 1'b1, 2 * OS);
    chk("b41_count", 32'(qb.size() - n0), 32'd1);
    if (qb.size() > n0) chk_rec("b41", qb[$], d, model_pe(d, 2, pb), 1'b1);
    chk("b41_busy", 32'(busy_b), 32'd0);

    // Two back-to-back frames with no idle gap.
    n0 = qb.size();
    d  = 9'($urandom_range(0, 127));
    d2 = 9'($urandom_range(0, 127));
    send_frame(1, 7, d, 1, good_pb(d, 2), 2, 2'b11, sc);
    send_frame(1, 7, d2, 1, good_pb(d2, 2), 2, 2'b11, sc2);
    drive(1, 1'b1, 2 * OS);
    chk("b2b_count", 32'(qb.size() - n0), 32'd2);
    if (qb.size() >= n0 + 2) begin
      chk_rec("b2b_first", qb[n0], d, 1'b0, 1'b0);
      chk_rec("b2b_second", qb[n0 + 1], d2, 1'b0, 1'b0);
      chk("b2b_latency", 32'(qb[n0].cyc - sc - 1), 32'(latency(7, 1, 2)));
      chk("b2b_spacing", 32'(qb[n0 + 1].cyc - qb[n0].cyc), 32'(sc2 - sc));
      chk("b2b_period", 32'(sc2 - sc), 32'((1 + 7 + 1 + 2) * OS));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
